mem_arbiter: RTL
================

# mem_arbiter

Two-into-one memory arbiter between the core's instruction and data memory ports and a single shared single-port memory or bus slave, for systems with one unified SRAM. It accepts the core's valid/ready transactions on two upstream ports and presents them one at a time on one downstream port. Grants alternate round-robin when both ports are pending. Each granted request is latched, so the downstream transaction stays stable whatever the requester does afterwards.

## Interface
Parameters:
- ADDR_WIDTH, default `RISCV_ADDR_WIDTH (32): address width, all ports.
- DATA_WIDTH, default `RISCV_WORD_WIDTH (32): data width, all ports.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- imem_valid_i  in  1  instruction request pending.
- imem_ready_o  out  1  instruction transaction complete; rdata valid this cycle.
- imem_addr_i  in  ADDR_WIDTH  instruction address.
- imem_wdata_i  in  DATA_WIDTH  instruction write data.
- imem_we_i  in  4  instruction byte write enables.
- imem_rdata_o  out  DATA_WIDTH  instruction read data.
- dmem_valid_i, dmem_ready_o, dmem_addr_i, dmem_wdata_i, dmem_we_i, dmem_rdata_o: same as the imem signals, for the data port.
- mem_valid_o  out  1  downstream request.
- mem_ready_i  in  1  downstream completion, one-cycle pulse.
- mem_addr_o  out  ADDR_WIDTH  latched address.
- mem_wdata_o  out  DATA_WIDTH  latched write data.
- mem_we_o  out  4  latched byte enables.
- mem_rdata_i  in  DATA_WIDTH  downstream read data, valid when mem_ready_i=1.

## Operation
- States: IDLE, GNT_I, GNT_D. Register last_grant records the port granted most recently (0 = imem, 1 = dmem).
- IDLE, only one port valid: go to that port's GNT state. Latch its addr/wdata/we into the mem_* registers. Set last_grant.
- IDLE, both ports valid: grant the port not in last_grant.
- GNT_x: mem_valid_o=1 and the mem_* registers hold. On mem_ready_i=1:
  - x_ready_o=1 combinationally in the same cycle; x_rdata_o=mem_rdata_i.
  - Next state is the other port's GNT state if that port is valid (latching its request). Otherwise IDLE.
  - The arbiter never regrants the completing port directly, because that port's valid is still high for the old transaction.
- The non-granted port's ready_o is always 0.
- x_rdata_o = mem_rdata_i whenever the grant is x; otherwise 0.
- Requester drops valid while granted: the downstream transaction continues unchanged until mem_ready_i; x_ready_o still pulses and the requester ignores it. A transaction never aborts downstream.
- mem_ready_i while in IDLE: ignored; no upstream ready asserted.
- rst=1 overrides everything, including mid-transaction; the pending downstream access is abandoned.

## Timing
- Reset values: state=IDLE, last_grant=0 (so dmem wins the first tie), mem_valid_o=0, mem_addr_o=0, mem_wdata_o=0, mem_we_o=0, imem_ready_o=0, dmem_ready_o=0, rdata outputs 0.
- Latency from IDLE: valid seen in cycle N → mem_valid_o=1 in N+1 → ready_o in the same cycle as mem_ready_i (zero added return latency).
- Back-to-back:
  - Handover to the other port costs no bubble; mem_valid_o stays high across the switch with new latched fields.
  - Same-port back-to-back costs one IDLE cycle.
- Fairness: with both ports continuously valid, grants alternate strictly I/D/I/D.
- mem_* outputs change only on the clock edge that grants.

## Structure
- State encodings (IDLE/GNT_I/GNT_D) and port-index constants go in a shared `arb_defines.v` next to `riscv_defines.v`.
- One natural sub-module: `rr_pick2`, a combinational two-requester round-robin picker (inputs req[1:0] and last; output grant index and a grant-valid flag).
- The state register, latch registers and response muxing stay in mem_arbiter.

## Test plan
- Reset: hold rst 2 cycles with both valids high → all outputs 0 and no grant. After release, dmem is granted first (last_grant=0).
- Single imem read, addr 0x100, slave ready 3 cycles after request with rdata 0xDEADBEEF → mem_valid_o one cycle after imem_valid_i; imem_ready_o pulses with rdata 0xDEADBEEF; dmem_ready_o stays 0.
- Both valid continuously, slave ready every cycle → grant sequence D,I,D,I; mem_valid_o never drops after the first grant.
- Dmem write addr 0x2000, wdata 0x12345678, we=4'b0011; requester changes addr to 0x3000 and drops valid one cycle after grant → downstream keeps 0x2000/0x12345678/0011 until ready.
- Stray mem_ready_i in IDLE → no upstream ready, state stays IDLE.
- rst asserted during GNT_I → next cycle IDLE and mem_valid_o=0. Then a fresh imem request completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-into-one memory arbiter: FSM states,
// port indices and the default bus widths of the core.
package mem_arbiter_pkg;

  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_t;

  function automatic arb_state_t gnt_state(input logic port);
    return (port == PORT_D) ? ST_GNT_D : ST_GNT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-requester round-robin picker: on a tie the requester
// that was not granted last wins.
module mem_arbiter_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    if (&req) begin
      grant = ~last;
    end else begin
      grant = req[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter from the core's instruction and data ports onto one
// shared memory port; each granted request is latched until completion.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = RISCV_ADDR_WIDTH,
  parameter int DATA_WIDTH = RISCV_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,

  input  logic                  dmem_valid_i,
  output logic                  dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]            dmem_we_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,

  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  arb_state_t            state;
  logic                  last_grant;
  logic [1:0]            port_valid;
  logic [ADDR_WIDTH-1:0] port_addr  [2];
  logic [DATA_WIDTH-1:0] port_wdata [2];
  logic [3:0]            port_we    [2];
  logic [1:0]            port_ready;
  logic [DATA_WIDTH-1:0] port_rdata [2];
  logic                  pick;
  logic                  pick_valid;
  logic                  other;

  assign port_valid         = {dmem_valid_i, imem_valid_i};
  assign port_addr[PORT_I]  = imem_addr_i;
  assign port_addr[PORT_D]  = dmem_addr_i;
  assign port_wdata[PORT_I] = imem_wdata_i;
  assign port_wdata[PORT_D] = dmem_wdata_i;
  assign port_we[PORT_I]    = imem_we_i;
  assign port_we[PORT_D]    = dmem_we_i;

  // The port not currently being served; only meaningful in a grant state.
  assign other = (state == ST_GNT_D) ? PORT_I : PORT_D;

  mem_arbiter_rr_pick2 u_pick (
    .req         (port_valid),
    .last        (last_grant),
    .grant       (pick),
    .grant_valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_grant  <= PORT_I;
      mem_valid_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state       <= gnt_state(pick);
            last_grant  <= pick;
            mem_valid_o <= 1'b1;
            mem_addr_o  <= port_addr[pick];
            mem_wdata_o <= port_wdata[pick];
            mem_we_o    <= port_we[pick];
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          // The completing port's valid still refers to the finished access,
          // so only the other port may be handed the bus without a bubble.
          if (mem_ready_i) begin
            if (port_valid[other]) begin
              state       <= gnt_state(other);
              last_grant  <= other;
              mem_addr_o  <= port_addr[other];
              mem_wdata_o <= port_wdata[other];
              mem_we_o    <= port_we[other];
            end else begin
              state       <= ST_IDLE;
              mem_valid_o <= 1'b0;
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          mem_valid_o <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic granted;
    assign granted         = (state == gnt_state(1'(gi)));
    assign port_ready[gi]  = granted & mem_ready_i;
    assign port_rdata[gi]  = granted ? mem_rdata_i : '0;
  end

  assign imem_ready_o = port_ready[PORT_I];
  assign dmem_ready_o = port_ready[PORT_D];
  assign imem_rdata_o = port_rdata[PORT_I];
  assign dmem_rdata_o = port_rdata[PORT_D];

endmodule
